demux_stream: RTL and testbench
===============================

Name: demux_stream

Overview:
- Registered, parametrised 1-to-NUM_OUT demultiplexer with a valid/ready handshake on every port.
- Routes each input word to the output channel chosen by in_key, or to all channels when broadcast is requested.
- Each channel has a one-entry holding register, so a stalled consumer blocks only traffic addressed to that channel.
- Sits between a single producer and NUM_OUT consumers, for example bus fan-out in the Guia datapath exercises.

Parameters:
WIDTH, 8, data word width in bits (>=1)
NUM_OUT, 4, number of output channels (2..16; need not be a power of two)
SEL_BITS, 2, width of in_key; must satisfy 2**SEL_BITS >= NUM_OUT
BCAST_EN, 1, 1 = honour in_bcast; 0 = in_bcast ignored and treated as 0

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  word to route
in_key  input  SEL_BITS  destination channel index
in_bcast  input  1  deliver the word to all channels
in_valid  input  1  producer offers a word
in_ready  output  1  block accepts the word this cycle
out_data  output  NUM_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
out_valid  output  NUM_OUT  channel i holds a word
out_ready  input  NUM_OUT  consumer i takes the word
err_key  output  1  sticky: a word with in_key >= NUM_OUT was dropped

Behaviour:
- Reset (synchronous, highest priority, applies at any cycle including mid-transfer):
  - out_valid = 0, out_data = 0, err_key = 0.
  - Words held in channel registers are discarded.
  - in_ready is combinational and is 0 while reset = 1.
- Per-channel state is implicit in out_valid[i]: EMPTY (0) or FULL (1).
- Channel i can accept a word when out_valid[i] = 0, or when out_valid[i] & out_ready[i] (drains and refills in the same cycle, so 1 word/cycle is sustained).
- Unicast (in_bcast = 0 or BCAST_EN = 0):
  - If in_key < NUM_OUT: in_ready = can_accept[in_key].
  - If in_key >= NUM_OUT: in_ready = 1. The word is consumed and dropped, and err_key is set and stays set until reset. No channel changes.
- Broadcast (BCAST_EN = 1, in_bcast = 1):
  - All-or-nothing: in_ready = AND of can_accept over all channels.
  - On acceptance every channel loads in_data and sets out_valid. in_key is ignored and err_key is unaffected.
- Transfer occurs when in_valid & in_ready.
- Latency: a word accepted in cycle N appears on out_data/out_valid in cycle N+1.
- out_data[i] is stable while out_valid[i] = 1 and out_ready[i] = 0.
- A channel whose word drains with no refill clears out_valid at the next edge; out_data keeps its last value.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- in_ready may depend combinationally on in_key, in_bcast and out_ready. It must not depend on in_valid.
- Simultaneous refill and drain on the same channel: the new word wins, out_valid stays 1, and no bubble is inserted.

Decomposition:
- No shared package is needed.
- The width check (2**SEL_BITS >= NUM_OUT) is an elaboration-time assertion in the module.
- One sub-module, demux_slot:
  - Holds one WIDTH-bit register plus its valid bit.
  - Ports: clk, reset, load, data, out_ready, out_data, out_valid, can_accept.
  - Instantiated NUM_OUT times in a generate loop.
  - Top-level logic is key decode, broadcast AND-reduction and the err_key flag.

Test Plan:
1. Reset then unicast, WIDTH=8, NUM_OUT=4, all out_ready=1:
   - Stimulus: send 0xA5 with key 2.
   - Required: next cycle out_valid = 4'b0100 and channel 2 data = 0xA5; following cycle out_valid = 0.
2. Back-pressure:
   - Stimulus: out_ready[1] = 0; send 0x11 then 0x22, both to key 1.
   - Required: second word stalls (in_ready = 0) and channel 1 holds 0x11 stable.
   - Stimulus: raise out_ready[1].
   - Required: 0x11 drains and 0x22 is accepted in the same cycle, appearing one cycle later.
   - Stimulus: meanwhile a word to key 3 is sent.
   - Required: it is accepted immediately.
3. Broadcast:
   - Stimulus: in_bcast = 1, 0x5A, with out_ready[0] = 0 and channel 0 full.
   - Required: in_ready = 0 and no channel loads.
   - Stimulus: release out_ready[0].
   - Required: all 4 channels show 0x5A, out_valid = 4'b1111.
   - With BCAST_EN = 0: the same stimulus routes only to in_key.
4. Invalid key, NUM_OUT=3, SEL_BITS=2:
   - Stimulus: send 0x77 with key 3.
   - Required: in_ready = 1, no out_valid change, err_key rises and stays 1.
   - Stimulus: a subsequent valid word to key 0.
   - Required: delivered normally.
5. Reset mid-operation:
   - Stimulus: assert reset with channels 0 and 2 full and in_valid = 1.
   - Required: next cycle out_valid = 0, err_key = 0, and in_ready = 0 while reset is high.
6. Throughput:
   - Stimulus: 16 consecutive words, keys 0,1,2,3 repeating, all out_ready = 1.
   - Required: one accepted per cycle, each seen on its channel exactly one cycle later, in order.

Source files
------------

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single output channel.
// Accepts a new word when empty or when draining in the same cycle.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             can_accept
);

    assign can_accept = ~out_valid | out_ready;

    // Hold register: a refill wins over a drain, so no bubble is inserted
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NUM_OUT demultiplexer with valid/ready
// on every port, optional broadcast and a sticky bad-key flag.
module demux_stream #(
    parameter int WIDTH    = 8,
    parameter int NUM_OUT  = 4,
    parameter int SEL_BITS = 2,
    parameter bit BCAST_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_BITS-1:0]      in_key,
    input  logic                     in_bcast,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic                     err_key
);

    if ((2 ** SEL_BITS) < NUM_OUT) begin : g_bad_sel
        $error("demux_stream: SEL_BITS too narrow for NUM_OUT");
    end

    logic [NUM_OUT-1:0] can_accept;
    logic [NUM_OUT-1:0] load;
    logic               bcast;
    logic               key_ok;
    logic               sel_ok;
    logic               take;

    // Decode destination, derive in_ready and per-channel load strobes
    always_comb begin
        bcast  = BCAST_EN & in_bcast;
        key_ok = 32'(in_key) < NUM_OUT;
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (32'(in_key) == i) sel_ok = can_accept[i];
        end
        if (reset)       in_ready = 1'b0;
        else if (bcast)  in_ready = &can_accept;
        else if (key_ok) in_ready = sel_ok;
        else             in_ready = 1'b1;
        take = in_valid & in_ready;
        load = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            load[i] = take & (bcast | (key_ok & (32'(in_key) == i)));
        end
    end

    // Sticky flag for words dropped because of an out-of-range key
    always_ff @(posedge clk) begin
        if (reset)
            err_key <= 1'b0;
        else if (take & ~bcast & ~key_ok)
            err_key <= 1'b1;
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .load       (load[i]),
            .data       (in_data),
            .out_ready  (out_ready[i]),
            .out_data   (out_data[i*WIDTH +: WIDTH]),
            .out_valid  (out_valid[i]),
            .can_accept (can_accept[i])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: two configurations (4 ch + bcast, 3 ch no bcast)
// driven in lockstep, checked by per-channel queues.
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic [2:0]  in_key = '0;
    logic        in_bcast = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  ready_a = '0;
    logic [2:0]  ready_b = '0;

    logic        in_ready_a, in_ready_b;
    logic [31:0] out_data_a;
    logic [23:0] out_data_b;
    logic [3:0]  out_valid_a;
    logic [2:0]  out_valid_b;
    logic        err_a, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q [2][4][$];
    logic [7:0] m_last [2][4];
    bit         m_err [2];

    always #5 clk = ~clk;

    demux_stream #(
        .WIDTH(8), .NUM_OUT(4), .SEL_BITS(3), .BCAST_EN(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_key(in_key),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(ready_a), .err_key(err_a)
    );

    demux_stream #(
        .WIDTH(8), .NUM_OUT(3), .SEL_BITS(2), .BCAST_EN(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_key(in_key[1:0]),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(ready_b), .err_key(err_b)
    );

    function automatic int nout(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic get_ov(int d, int i);
        return (d == 0) ? out_valid_a[i] : out_valid_b[i];
    endfunction

    function automatic logic get_or(int d, int i);
        return (d == 0) ? ready_a[i] : ready_b[i];
    endfunction

    function automatic logic [7:0] get_od(int d, int i);
        return (d == 0) ? out_data_a[i*8 +: 8] : out_data_b[i*8 +: 8];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs, check against the queue model, then update it
    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic [2:0] k, input logic b,
                        input logic [3:0] ra, input logic [2:0] rb);
        int  n;
        int  kk;
        bit  bc;
        bit  all_ok;
        bit  exp_rdy;
        bit  can [4];
        @(negedge clk);
        reset = r; in_valid = v; in_data = d; in_key = k;
        in_bcast = b; ready_a = ra; ready_b = rb;
        #1;
        for (int dd = 0; dd < 2; dd++) begin
            n  = nout(dd);
            kk = (dd == 0) ? int'(k) : int'(k[1:0]);
            bc = (dd == 0) && b;
            all_ok = 1'b1;
            for (int i = 0; i < n; i++) begin
                can[i] = (q[dd][i].size() == 0) || get_or(dd, i);
                all_ok = all_ok && can[i];
            end
            if (r)           exp_rdy = 1'b0;
            else if (bc)     exp_rdy = all_ok;
            else if (kk < n) exp_rdy = can[kk];
            else             exp_rdy = 1'b1;
            chk($sformatf("in_ready[%0d]", dd),
                int'((dd == 0) ? in_ready_a : in_ready_b), int'(exp_rdy));
            chk($sformatf("err_key[%0d]", dd),
                int'((dd == 0) ? err_a : err_b), int'(m_err[dd]));
            for (int i = 0; i < n; i++) begin
                chk($sformatf("out_valid[%0d][%0d]", dd, i),
                    int'(get_ov(dd, i)), int'(q[dd][i].size() != 0));
                if (q[dd][i].size() == 0)
                    chk($sformatf("idle_data[%0d][%0d]", dd, i),
                        int'(get_od(dd, i)), int'(m_last[dd][i]));
            end
            if (r) begin
                m_err[dd] = 1'b0;
                for (int i = 0; i < n; i++) begin
                    q[dd][i].delete();
                    m_last[dd][i] = 8'h00;
                end
            end else if (v && exp_rdy) begin
                if (bc) begin
                    for (int i = 0; i < n; i++) begin
                        q[dd][i].push_back(d);
                        m_last[dd][i] = d;
                    end
                end else if (kk < n) begin
                    q[dd][kk].push_back(d);
                    m_last[dd][kk] = d;
                end else begin
                    m_err[dd] = 1'b1;
                end
            end
        end
    endtask

    // Monitor: just before each edge, compare held words and retire drains
    always @(negedge clk) begin
        #4;
        if (!reset) begin
            for (int dd = 0; dd < 2; dd++) begin
                for (int i = 0; i < nout(dd); i++) begin
                    if (get_ov(dd, i) && q[dd][i].size() != 0) begin
                        chk($sformatf("out_data[%0d][%0d]", dd, i),
                            int'(get_od(dd, i)), int'(q[dd][i][0]));
                        if (get_or(dd, i)) void'(q[dd][i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        for (int dd = 0; dd < 2; dd++) begin
            m_err[dd] = 1'b0;
            for (int i = 0; i < 4; i++) m_last[dd][i] = 8'h00;
        end
        step(1, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        step(1, 1, 8'h99, 3'd1, 0, 4'hF, 3'h7);
        // unicast
        step(0, 1, 8'hA5, 3'd2, 0, 4'hF, 3'h7);
        step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        // back-pressure on channel 1
        step(0, 1, 8'h11, 3'd1, 0, 4'hD, 3'h5);
        step(0, 1, 8'h22, 3'd1, 0, 4'hD, 3'h5);
        step(0, 1, 8'h22, 3'd1, 0, 4'hD, 3'h5);
        step(0, 1, 8'h22, 3'd1, 0, 4'hF, 3'h7);
        step(0, 1, 8'h33, 3'd3, 0, 4'hF, 3'h7);
        step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        // broadcast blocked by full channel 0, then released
        step(0, 1, 8'h44, 3'd0, 0, 4'hE, 3'h6);
        step(0, 1, 8'h5A, 3'd0, 1, 4'hE, 3'h6);
        step(0, 1, 8'h5A, 3'd0, 1, 4'hF, 3'h7);
        step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        // out-of-range key, then a normal word
        step(0, 1, 8'h77, 3'd7, 0, 4'hF, 3'h7);
        step(0, 1, 8'h78, 3'd0, 0, 4'hF, 3'h7);
        step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        // reset with channels 0 and 2 full
        step(0, 1, 8'h01, 3'd0, 0, 4'hA, 3'h2);
        step(0, 1, 8'h02, 3'd2, 0, 4'hA, 3'h2);
        step(1, 1, 8'h03, 3'd1, 0, 4'hA, 3'h2);
        step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        // throughput
        for (int j = 0; j < 16; j++)
            step(0, 1, 8'(8'h80 + j), 3'(j % 4), 0, 4'hF, 3'h7);
        step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        // randomized traffic
        for (int j = 0; j < 600; j++)
            step(($urandom % 80) == 0, ($urandom % 4) != 0,
                 8'($urandom), 3'($urandom), ($urandom % 5) == 0,
                 4'($urandom | $urandom), 3'($urandom | $urandom));
        for (int j = 0; j < 3; j++)
            step(0, 0, 8'h00, 3'd0, 0, 4'hF, 3'h7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
